// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 Hz raster timing shared by the timing generator and the pixel colorizers.
package vga_timing_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FRONT  = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BACK   = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FRONT  = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BACK   = 33;

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic H_SYNC_POL = 1'b0;
    localparam logic V_SYNC_POL = 1'b0;

    typedef struct packed {
        logic video_on;
        logic hsync;
        logic vsync;
    } timing_flags_t;

    // Maps "inside the sync interval" onto the pin level for the given polarity.
    function automatic logic sync_level(input logic active, input logic pol);
        return active ? pol : ~pol;
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Enable-gated shift register with a per-bit asynchronous reset value; depth 0 is a plain wire.
module sync_delay_line #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic w_unused;
            assign w_unused = ^{i_clk, i_reset_n, i_en};
            assign o_data   = i_data;
        end else begin : g_pipe
            logic [WIDTH-1:0] r_stage [DEPTH];

            always_ff @(posedge i_clk or negedge i_reset_n) begin
                if (!i_reset_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= RESET_VAL;
                    end
                end else if (i_en) begin
                    r_stage[0] <= i_data;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign o_data = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/display_timing_gen.sv
// Raster scan generator: pixel/line counters, zero-skew registered sync/blank decodes and
// a delayed copy of those decodes aligned with the colorizers' block-RAM read latency.
module display_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE   = vga_timing_pkg::H_ACTIVE,
    parameter int   H_FRONT    = vga_timing_pkg::H_FRONT,
    parameter int   H_SYNC     = vga_timing_pkg::H_SYNC,
    parameter int   H_BACK     = vga_timing_pkg::H_BACK,
    parameter int   V_ACTIVE   = vga_timing_pkg::V_ACTIVE,
    parameter int   V_FRONT    = vga_timing_pkg::V_FRONT,
    parameter int   V_SYNC     = vga_timing_pkg::V_SYNC,
    parameter int   V_BACK     = vga_timing_pkg::V_BACK,
    parameter logic H_SYNC_POL = vga_timing_pkg::H_SYNC_POL,
    parameter logic V_SYNC_POL = vga_timing_pkg::V_SYNC_POL,
    parameter int   SYNC_DELAY = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               pix_en,
    output logic signed [31:0] pixel_row,
    output logic signed [31:0] pixel_column,
    output logic               video_on,
    output logic               horiz_sync,
    output logic               vert_sync,
    output logic               frame_start,
    output logic               video_on_dly,
    output logic               horiz_sync_dly,
    output logic               vert_sync_dly
);

    localparam int H_TOTAL_L = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL_L = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int H_W       = $clog2(H_TOTAL_L);
    localparam int V_W       = $clog2(V_TOTAL_L);

    localparam logic [H_W-1:0] H_LAST    = H_W'(H_TOTAL_L - 1);
    localparam logic [H_W-1:0] H_VIS_END = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0] H_SS      = H_W'(H_ACTIVE + H_FRONT);
    localparam logic [H_W-1:0] H_SE      = H_W'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [V_W-1:0] V_LAST    = V_W'(V_TOTAL_L - 1);
    localparam logic [V_W-1:0] V_VIS_END = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0] V_SS      = V_W'(V_ACTIVE + V_FRONT);
    localparam logic [V_W-1:0] V_SE      = V_W'(V_ACTIVE + V_FRONT + V_SYNC);

    localparam timing_flags_t FLAGS_RST = '{video_on: 1'b0, hsync: ~H_SYNC_POL, vsync: ~V_SYNC_POL};

    logic [H_W-1:0] r_h_cnt;
    logic [V_W-1:0] r_v_cnt;
    logic [H_W-1:0] w_h_nxt;
    logic [V_W-1:0] w_v_nxt;
    logic           w_h_wrap;
    logic           w_v_wrap;
    logic           w_video_nxt;
    logic           w_hsync_nxt;
    logic           w_vsync_nxt;

    logic r_video_on;
    logic r_hsync;
    logic r_vsync;
    logic r_frame_start;

    timing_flags_t w_flags;
    timing_flags_t w_flags_dly;

    // Decodes use the next-state counters so the registered flags land on the same edge as the coordinates.
    always_comb begin
        w_h_wrap = (r_h_cnt == H_LAST);
        w_v_wrap = (r_v_cnt == V_LAST);
        w_h_nxt  = r_h_cnt;
        w_v_nxt  = r_v_cnt;
        if (pix_en) begin
            w_h_nxt = w_h_wrap ? '0 : r_h_cnt + 1'b1;
            if (w_h_wrap) begin
                w_v_nxt = w_v_wrap ? '0 : r_v_cnt + 1'b1;
            end
        end
        w_video_nxt = (w_h_nxt < H_VIS_END) && (w_v_nxt < V_VIS_END);
        w_hsync_nxt = sync_level((w_h_nxt >= H_SS) && (w_h_nxt < H_SE), H_SYNC_POL);
        w_vsync_nxt = sync_level((w_v_nxt >= V_SS) && (w_v_nxt < V_SE), V_SYNC_POL);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_video_on    <= 1'b0;
            r_hsync       <= ~H_SYNC_POL;
            r_vsync       <= ~V_SYNC_POL;
            r_frame_start <= 1'b0;
        end else begin
            r_h_cnt       <= w_h_nxt;
            r_v_cnt       <= w_v_nxt;
            r_video_on    <= w_video_nxt;
            r_hsync       <= w_hsync_nxt;
            r_vsync       <= w_vsync_nxt;
            r_frame_start <= pix_en && w_h_wrap && w_v_wrap;
        end
    end

    assign w_flags.video_on = r_video_on;
    assign w_flags.hsync    = r_hsync;
    assign w_flags.vsync    = r_vsync;

    sync_delay_line #(
        .WIDTH     ($bits(timing_flags_t)),
        .DEPTH     (SYNC_DELAY),
        .RESET_VAL (FLAGS_RST)
    ) u_sync_delay (
        .i_clk     (clk),
        .i_reset_n (reset_n),
        .i_en      (pix_en),
        .i_data    (w_flags),
        .o_data    (w_flags_dly)
    );

    assign pixel_column   = $signed(32'(r_h_cnt));
    assign pixel_row      = $signed(32'(r_v_cnt));
    assign video_on       = r_video_on;
    assign horiz_sync     = r_hsync;
    assign vert_sync      = r_vsync;
    assign frame_start    = r_frame_start;
    assign video_on_dly   = w_flags_dly.video_on;
    assign horiz_sync_dly = w_flags_dly.hsync;
    assign vert_sync_dly  = w_flags_dly.vsync;

endmodule

// File: tb/tb_display_timing_gen.sv
// Directed bench: full-size timing with SYNC_DELAY 1 and 0, plus a shrunken active-high
// geometry (25x19) so frame-level behaviour fits in a short run.
module tb_display_timing_gen;

    logic clk = 1'b0;
    logic reset_n;
    logic pix_en;

    always #5 clk = ~clk;

    logic signed [31:0] d1_row, d1_col, d0_row, d0_col, ds_row, ds_col;
    logic d1_vo, d1_hs, d1_vs, d1_fs, d1_vod, d1_hsd, d1_vsd;
    logic d0_vo, d0_hs, d0_vs, d0_fs, d0_vod, d0_hsd, d0_vsd;
    logic ds_vo, ds_hs, ds_vs, ds_fs, ds_vod, ds_hsd, ds_vsd;

    int assertCount = 0;
    int failCount   = 0;

    display_timing_gen #(.SYNC_DELAY(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .pix_en(pix_en),
        .pixel_row(d1_row), .pixel_column(d1_col),
        .video_on(d1_vo), .horiz_sync(d1_hs), .vert_sync(d1_vs), .frame_start(d1_fs),
        .video_on_dly(d1_vod), .horiz_sync_dly(d1_hsd), .vert_sync_dly(d1_vsd)
    );

    display_timing_gen #(.SYNC_DELAY(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .pix_en(pix_en),
        .pixel_row(d0_row), .pixel_column(d0_col),
        .video_on(d0_vo), .horiz_sync(d0_hs), .vert_sync(d0_vs), .frame_start(d0_fs),
        .video_on_dly(d0_vod), .horiz_sync_dly(d0_hsd), .vert_sync_dly(d0_vsd)
    );

    display_timing_gen #(
        .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
        .V_ACTIVE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .SYNC_DELAY(1)
    ) duts (
        .clk(clk), .reset_n(reset_n), .pix_en(pix_en),
        .pixel_row(ds_row), .pixel_column(ds_col),
        .video_on(ds_vo), .horiz_sync(ds_hs), .vert_sync(ds_vs), .frame_start(ds_fs),
        .video_on_dly(ds_vod), .horiz_sync_dly(ds_hsd), .vert_sync_dly(ds_vsd)
    );

    // One clock with the given pix_en; returns at the following falling edge for sampling.
    task automatic applyStimulus(input logic en);
        pix_en = en;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkFlag(input string tag, input logic observed, input logic expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic resetDuts();
        reset_n = 1'b0;
        applyStimulus(1'b0);
        applyStimulus(1'b0);
        reset_n = 1'b1;
        applyStimulus(1'b0);
    endtask

    initial begin
        int   expCol, hsLowCount, hsFirst, hsLast;
        int   fsCount, fsFirst, fsSecond, voCount, vsCount, hsCount, vsRowFirst, vsRowLast;
        logic expHs, expVo, prevHs, prevVo;

        reset_n = 1'b0;
        pix_en  = 1'b0;
        applyStimulus(1'b0);
        applyStimulus(1'b0);
        checkOutput("rst_col", d1_col, 0);
        checkOutput("rst_row", d1_row, 0);
        checkFlag("rst_video", d1_vo, 1'b0);
        checkFlag("rst_hsync", d1_hs, 1'b1);
        checkFlag("rst_vsync", d1_vs, 1'b1);
        checkFlag("rst_fs", d1_fs, 1'b0);
        checkFlag("rst_video_dly", d1_vod, 1'b0);
        checkFlag("rst_hsync_dly", d1_hsd, 1'b1);
        checkFlag("rst_vsync_dly", d1_vsd, 1'b1);
        checkFlag("rst_small_hsync", ds_hs, 1'b0);
        checkFlag("rst_small_vsync", ds_vs, 1'b0);
        checkFlag("rst_small_vsync_dly", ds_vsd, 1'b0);

        reset_n = 1'b1;
        applyStimulus(1'b0);
        checkFlag("rel_video", d1_vo, 1'b1);
        checkOutput("rel_col", d1_col, 0);
        checkFlag("rel_fs", d1_fs, 1'b0);
        checkFlag("rel_video_dly", d1_vod, 1'b0);
        checkFlag("rel_sd0_video_dly", d0_vod, 1'b1);
        checkFlag("rel_small_video", ds_vo, 1'b1);

        $display("[TB] one line at pix_en every 4th clk");
        hsLowCount = 0; hsFirst = -1; hsLast = -1;
        prevHs = 1'b1; prevVo = 1'b1;
        for (int t = 1; t <= 800; t++) begin
            applyStimulus(1'b0);
            applyStimulus(1'b0);
            applyStimulus(1'b0);
            checkOutput("hold_col", d1_col, 32'((t - 1) % 800));
            applyStimulus(1'b1);
            expCol = t % 800;
            expHs  = !(expCol >= 656 && expCol < 752);
            expVo  = (expCol < 640);
            checkOutput("line_col", d1_col, 32'(expCol));
            checkFlag("line_hsync", d1_hs, expHs);
            checkFlag("line_video", d1_vo, expVo);
            checkFlag("line_hsync_dly", d1_hsd, prevHs);
            checkFlag("line_video_dly", d1_vod, prevVo);
            checkFlag("sd0_hsync_dly", d0_hsd, expHs);
            checkFlag("sd0_video_dly", d0_vod, expVo);
            if (d1_hs == 1'b0) begin
                if (hsLowCount == 0) hsFirst = d1_col;
                hsLast = d1_col;
                hsLowCount++;
            end
            if (t == 799) checkOutput("row_before_wrap", d1_row, 0);
            prevHs = expHs;
            prevVo = expVo;
        end
        checkOutput("row_after_wrap", d1_row, 1);
        checkOutput("hsync_low_ticks", 32'(hsLowCount), 96);
        checkOutput("hsync_first_col", 32'(hsFirst), 656);
        checkOutput("hsync_last_col", 32'(hsLast), 751);
        checkFlag("line_vsync", d1_vs, 1'b1);

        $display("[TB] small geometry frames with pix_en tied high");
        resetDuts();
        fsCount = 0; fsFirst = -1; fsSecond = -1;
        voCount = 0; vsCount = 0; hsCount = 0; vsRowFirst = -1; vsRowLast = -1;
        for (int i = 1; i <= 1000; i++) begin
            applyStimulus(1'b1);
            if (ds_fs) begin
                fsCount++;
                if (fsCount == 1) fsFirst = i;
                else if (fsCount == 2) fsSecond = i;
                checkOutput("wrap_col", ds_col, 0);
                checkOutput("wrap_row", ds_row, 0);
            end
            if (i == 474) begin
                checkOutput("last_col", ds_col, 24);
                checkOutput("last_row", ds_row, 18);
            end
            if (i == 476) checkFlag("fs_one_clk", ds_fs, 1'b0);
            if (i >= 475 && i < 950) begin
                if (ds_vo) voCount++;
                if (ds_hs) hsCount++;
                if (ds_vs) begin
                    vsCount++;
                    if (vsRowFirst < 0) vsRowFirst = ds_row;
                    vsRowLast = ds_row;
                end
            end
        end
        checkOutput("fs_count", 32'(fsCount), 2);
        checkOutput("fs_first", 32'(fsFirst), 475);
        checkOutput("fs_interval", 32'(fsSecond - fsFirst), 475);
        checkOutput("video_clks", 32'(voCount), 192);
        checkOutput("hsync_clks", 32'(hsCount), 76);
        checkOutput("vsync_clks", 32'(vsCount), 50);
        checkOutput("vsync_row_first", 32'(vsRowFirst), 14);
        checkOutput("vsync_row_last", 32'(vsRowLast), 15);

        $display("[TB] freeze at last visible pixel");
        resetDuts();
        for (int i = 0; i < 290; i++) applyStimulus(1'b1);
        checkOutput("frz_col_start", ds_col, 15);
        checkOutput("frz_row_start", ds_row, 11);
        for (int i = 0; i < 50; i++) begin
            applyStimulus(1'b0);
            checkOutput("frz_col", ds_col, 15);
            checkOutput("frz_row", ds_row, 11);
            checkFlag("frz_video", ds_vo, 1'b1);
            checkFlag("frz_hsync", ds_hs, 1'b0);
        end
        applyStimulus(1'b1);
        checkOutput("unfrz_col", ds_col, 16);
        checkOutput("unfrz_row", ds_row, 11);
        checkFlag("unfrz_video", ds_vo, 1'b0);
        checkFlag("unfrz_video_dly", ds_vod, 1'b1);

        $display("[TB] asynchronous reset mid-frame");
        resetDuts();
        for (int i = 0; i < 185; i++) applyStimulus(1'b1);
        checkOutput("pre_rst_col", ds_col, 10);
        checkOutput("pre_rst_row", ds_row, 7);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_col", ds_col, 0);
        checkOutput("async_row", ds_row, 0);
        checkFlag("async_video", ds_vo, 1'b0);
        checkFlag("async_video_dly", ds_vod, 1'b0);
        checkOutput("async_full_col", d1_col, 0);
        checkFlag("async_full_video", d1_vo, 1'b0);
        checkFlag("async_full_hsync_dly", d1_hsd, 1'b1);
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(1'b0);
        checkFlag("post_rst_video", ds_vo, 1'b1);
        checkOutput("post_rst_col", ds_col, 0);
        checkFlag("post_rst_fs", ds_fs, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(1'b1);
            checkOutput("post_rst_step_col", ds_col, 32'(k));
            checkFlag("post_rst_no_fs", ds_fs, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
